// File: rtl/halloween_effect_ctrl_if.sv
// rtl/halloween_effect_ctrl_if.sv - opcode handshake between the opcode mux and the effect controller
interface halloween_effect_ctrl_if;
    logic       op_valid;
    logic [3:0] opcode;
    logic       op_ready;

    modport master (output op_valid, output opcode, input op_ready);
    modport slave  (input op_valid, input opcode, output op_ready);
endinterface

// File: rtl/halloween_effect_ctrl.sv
// rtl/halloween_effect_ctrl.sv - decodes effect opcodes and drives timed lights, sound, servos and fog
module halloween_effect_ctrl #(
    parameter int SOUND_CYCLES = 8,
    parameter int MOVE_CYCLES  = 4,
    parameter int FOG_CYCLES   = 6,
    parameter int FOG_COOLDOWN = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    halloween_effect_ctrl_if.slave  op_if,
    output logic                    power_on,
    output logic [1:0]              color,
    output logic                    sound_active,
    output logic [1:0]              sound_id,
    output logic                    wave_hands,
    output logic                    move_jaw,
    output logic                    fog_on,
    output logic                    fog_cooling,
    output logic [7:0]              illegal_cnt
);
    localparam int SW = $clog2(SOUND_CYCLES + 1);
    localparam int MW = $clog2(MOVE_CYCLES + 1);
    localparam int FW = $clog2(FOG_CYCLES + 1);
    localparam int CW = $clog2(FOG_COOLDOWN + 1);
    localparam logic [SW-1:0] SND_LOAD  = SW'(SOUND_CYCLES);
    localparam logic [MW-1:0] MOVE_LOAD = MW'(MOVE_CYCLES);
    localparam logic [FW-1:0] FOG_LOAD  = FW'(FOG_CYCLES);
    localparam logic [CW-1:0] COOL_LOAD = CW'(FOG_COOLDOWN);

    typedef enum logic {ST_OFF, ST_ACTIVE} state_t;
    state_t state, state_nxt;

    logic [SW-1:0] snd_timer;
    logic [1:0]    snd_id_q;
    logic          snd_pend_v;
    logic [1:0]    snd_pend_id;
    logic [MW-1:0] wave_timer, jaw_timer;
    logic [FW-1:0] fog_timer;
    logic [CW-1:0] cool_timer;
    logic [7:0]    illegal_q;
    logic [1:0]    color_q;

    logic xfer, fog_idle;
    logic do_reset, do_color, do_sound, do_wave, do_jaw, do_fog, do_illegal;
    logic [1:0] item_id;

    assign op_if.op_ready = ~snd_pend_v;
    assign xfer     = op_if.op_valid & ~snd_pend_v;
    assign fog_idle = (fog_timer == '0) && (cool_timer == '0);
    assign item_id  = op_if.opcode[1:0] + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_OFF;
        else     state <= state_nxt;
    end

    // Only ON leaves OFF; everything else is swallowed until the decoration is powered.
    always_comb begin
        state_nxt  = state;
        do_reset   = 1'b0;
        do_color   = 1'b0;
        do_sound   = 1'b0;
        do_wave    = 1'b0;
        do_jaw     = 1'b0;
        do_fog     = 1'b0;
        do_illegal = 1'b0;
        if (xfer) begin
            if (state == ST_OFF) begin
                if (op_if.opcode == 4'b0000) state_nxt = ST_ACTIVE;
            end else begin
                case (op_if.opcode)
                    4'b0000:                   begin end
                    4'b0001:                   do_reset = 1'b1;
                    4'b0100, 4'b0101, 4'b0110: do_color = 1'b1;
                    4'b1000, 4'b1001, 4'b1010: do_sound = 1'b1;
                    4'b1100:                   do_wave  = 1'b1;
                    4'b1101:                   do_jaw   = 1'b1;
                    4'b1110:                   do_fog   = fog_idle;
                    default:                   do_illegal = 1'b1;
                endcase
            end
        end
    end

    // Last active cycle hands over straight to the queued sound, else to a newly accepted one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snd_timer   <= '0;
            snd_id_q    <= 2'd0;
            snd_pend_v  <= 1'b0;
            snd_pend_id <= 2'd0;
        end else if (do_reset) begin
            snd_timer   <= '0;
            snd_id_q    <= 2'd0;
            snd_pend_v  <= 1'b0;
            snd_pend_id <= 2'd0;
        end else if (snd_timer == '0) begin
            if (do_sound) begin
                snd_timer <= SND_LOAD;
                snd_id_q  <= item_id;
            end
        end else if (snd_timer == SW'(1)) begin
            if (snd_pend_v) begin
                snd_timer  <= SND_LOAD;
                snd_id_q   <= snd_pend_id;
                snd_pend_v <= 1'b0;
            end else if (do_sound) begin
                snd_timer <= SND_LOAD;
                snd_id_q  <= item_id;
            end else begin
                snd_timer <= '0;
                snd_id_q  <= 2'd0;
            end
        end else begin
            snd_timer <= snd_timer - SW'(1);
            if (do_sound) begin
                snd_pend_v  <= 1'b1;
                snd_pend_id <= item_id;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || do_reset) begin
            wave_timer <= '0;
            jaw_timer  <= '0;
        end else begin
            if (do_wave)                wave_timer <= MOVE_LOAD;
            else if (wave_timer != '0)  wave_timer <= wave_timer - MW'(1);
            if (do_jaw)                 jaw_timer  <= MOVE_LOAD;
            else if (jaw_timer != '0)   jaw_timer  <= jaw_timer - MW'(1);
        end
    end

    // Cooldown is loaded on the last firing cycle so the two windows abut with no gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || do_reset) begin
            fog_timer  <= '0;
            cool_timer <= '0;
        end else if (do_fog) begin
            fog_timer <= FOG_LOAD;
        end else if (fog_timer != '0) begin
            fog_timer <= fog_timer - FW'(1);
            if (fog_timer == FW'(1)) cool_timer <= COOL_LOAD;
        end else if (cool_timer != '0) begin
            cool_timer <= cool_timer - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 8'd0;
            color_q   <= 2'd0;
        end else begin
            if (do_illegal && illegal_q != 8'hFF) illegal_q <= illegal_q + 8'd1;
            if (do_reset)      color_q <= 2'd0;
            else if (do_color) color_q <= item_id;
        end
    end

    assign power_on     = (state == ST_ACTIVE);
    assign color        = color_q;
    assign sound_active = (snd_timer != '0);
    assign sound_id     = snd_id_q;
    assign wave_hands   = (wave_timer != '0);
    assign move_jaw     = (jaw_timer != '0);
    assign fog_on       = (fog_timer != '0);
    assign fog_cooling  = (cool_timer != '0);
    assign illegal_cnt  = illegal_q;
endmodule

// File: tb/tb_halloween_effect_ctrl.sv
// tb/tb_halloween_effect_ctrl.sv - directed bench with a time-window reference model of the effect controller
module tb_halloween_effect_ctrl;
    localparam int S = 8;
    localparam int M = 4;
    localparam int F = 6;
    localparam int C = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    halloween_effect_ctrl_if bus();
    logic       power_on, sound_active, wave_hands, move_jaw, fog_on, fog_cooling;
    logic [1:0] color, sound_id;
    logic [7:0] illegal_cnt;

    halloween_effect_ctrl #(
        .SOUND_CYCLES(S), .MOVE_CYCLES(M), .FOG_CYCLES(F), .FOG_COOLDOWN(C)
    ) dut (
        .clk(clk), .rst(rst), .op_if(bus),
        .power_on(power_on), .color(color), .sound_active(sound_active), .sound_id(sound_id),
        .wave_hands(wave_hands), .move_jaw(move_jaw), .fog_on(fog_on), .fog_cooling(fog_cooling),
        .illegal_cnt(illegal_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc   = 0;

    // Reference model: effects are windows of absolute edge numbers rather than counters.
    int         me = 0;
    logic       m_pow = 1'b0, m_sact = 1'b0, m_qv = 1'b0, m_rdy;
    logic [1:0] m_color = 2'd0, m_sid = 2'd0, m_qid = 2'd0;
    int         m_send = 0, m_we = 0, m_je = 0, m_fs = -1000, m_cnt = 0;
    logic [3:0] m_op;

    logic [18:0] act, expv;
    assign act = {bus.op_ready, power_on, color, sound_active, sound_id, wave_hands, move_jaw,
                  fog_on, fog_cooling, illegal_cnt};
    always_comb begin
        expv = {~m_qv, m_pow, m_color, m_sact, m_sid, (me < m_we), (me < m_je),
                (me >= m_fs && me < m_fs + F), (me >= m_fs + F && me < m_fs + F + C), 8'(m_cnt)};
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_pow = 1'b0; m_color = 2'd0; m_sact = 1'b0; m_sid = 2'd0; m_qv = 1'b0;
            m_we = 0; m_je = 0; m_fs = -1000; m_cnt = 0;
        end else begin
            m_rdy = ~m_qv;
            me++;
            if (m_sact && me == m_send) begin
                if (m_qv) begin
                    m_sid = m_qid; m_send = me + S; m_qv = 1'b0;
                end else begin
                    m_sact = 1'b0; m_sid = 2'd0;
                end
            end
            if (bus.op_valid && m_rdy) begin
                m_op = bus.opcode;
                if (!m_pow) begin
                    if (m_op == 4'h0) m_pow = 1'b1;
                end else if (m_op == 4'h1) begin
                    m_color = 2'd0; m_sact = 1'b0; m_sid = 2'd0; m_qv = 1'b0;
                    m_we = 0; m_je = 0; m_fs = -1000;
                end else if (m_op inside {4'h4, 4'h5, 4'h6}) begin
                    m_color = m_op[1:0] + 2'd1;
                end else if (m_op inside {4'h8, 4'h9, 4'hA}) begin
                    if (m_sact) begin
                        m_qv = 1'b1; m_qid = m_op[1:0] + 2'd1;
                    end else begin
                        m_sact = 1'b1; m_sid = m_op[1:0] + 2'd1; m_send = me + S;
                    end
                end else if (m_op == 4'hC) begin
                    m_we = me + M;
                end else if (m_op == 4'hD) begin
                    m_je = me + M;
                end else if (m_op == 4'hE) begin
                    if (!((me - 1) >= m_fs && (me - 1) < m_fs + F + C)) m_fs = me;
                end else if (m_op != 4'h0) begin
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL outputs edge=%0d got=%05h exp=%05h", cyc, act, expv);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] op);
        int n;
        n = 0;
        bus.op_valid = 1'b1;
        bus.opcode   = op;
        while (bus.op_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            total++;
            bad++;
            $display("FAIL send_timeout op=%0h ready=%b exp=1", op, bus.op_ready);
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
        end
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_edge(input int k);
        int n;
        n = 0;
        while (cyc < k && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    int a, t0, w;

    initial begin
        bus.op_valid = 1'b0;
        bus.opcode   = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset_vec", 32'(act), 32'h40000);
        rst = 1'b0;

        send(4'h4); send(4'hA); send(4'h3);
        chk("off_color", 32'(color), 32'd0);
        chk("off_sound", 32'(sound_active), 32'd0);
        chk("off_cnt", 32'(illegal_cnt), 32'd0);
        chk("off_power", 32'(power_on), 32'd0);
        send(4'h0); send(4'h5);
        chk("purple", 32'(color), 32'd2);
        chk("power_on", 32'(power_on), 32'd1);

        send(4'h8); a = acc;
        chk("scream_start", 32'(sound_id), 32'd1);
        send(4'h9);
        chk("queue_full", 32'(bus.op_ready), 32'd0);
        wait_edge(a + 7);
        chk("scream_last", 32'(sound_id), 32'd1);
        wait_edge(a + 8);
        chk("handover_id", 32'(sound_id), 32'd2);
        chk("handover_active", 32'(sound_active), 32'd1);
        chk("handover_ready", 32'(bus.op_ready), 32'd1);
        send(4'hA);
        chk("boo_accept_edge", 32'(acc), 32'(a + 9));
        wait_edge(a + 16);
        chk("boo_play", 32'(sound_id), 32'd3);
        wait_edge(a + 24);
        chk("sound_idle", 32'(sound_active), 32'd0);

        send(4'hE); t0 = acc;
        chk("fog_fire", 32'(fog_on), 32'd1);
        wait_edge(t0 + 2); send(4'hE);
        wait_edge(t0 + 5);
        chk("fog_last", 32'(fog_on), 32'd1);
        wait_edge(t0 + 6);
        chk("fog_end", 32'(fog_on), 32'd0);
        chk("cool_start", 32'(fog_cooling), 32'd1);
        wait_edge(t0 + 9); send(4'hE);
        wait_edge(t0 + 21);
        chk("cool_last", 32'(fog_cooling), 32'd1);
        wait_edge(t0 + 22);
        chk("cool_end", 32'({fog_on, fog_cooling}), 32'd0);
        send(4'hE);
        chk("fog_refire_edge", 32'(acc), 32'(t0 + 23));
        chk("fog_refire", 32'(fog_on), 32'd1);

        send(4'hC); w = acc;
        wait_edge(w + 1); send(4'hC); send(4'hD);
        wait_edge(w + 5);
        chk("wave_hold", 32'({wave_hands, move_jaw}), 32'd3);
        wait_edge(w + 6);
        chk("wave_end", 32'({wave_hands, move_jaw}), 32'd1);
        wait_edge(w + 7);
        chk("jaw_end", 32'(move_jaw), 32'd0);

        for (int i = 0; i < 300; i++) begin
            send(4'h3);
            if (i == 4) chk("cnt5", 32'(illegal_cnt), 32'd5);
        end
        chk("cnt_sat", 32'(illegal_cnt), 32'd255);
        send(4'h6); send(4'h8); send(4'hC); send(4'h1);
        chk("reset_cnt", 32'(illegal_cnt), 32'd255);
        chk("reset_power", 32'(power_on), 32'd1);
        chk("reset_fx", 32'({color, sound_active, wave_hands, fog_on, fog_cooling}), 32'd0);

        send(4'h9); send(4'hE);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async", 32'(act), 32'h40000);
        @(negedge clk) rst = 1'b0;
        send(4'hA); send(4'hE);
        chk("post_rst_off", 32'({power_on, sound_active, fog_on}), 32'd0);
        send(4'h0); send(4'hA);
        chk("post_rst_on", 32'(sound_id), 32'd3);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
